// File: rtl/mem_responder_if.sv
// mem_responder_if: request/response bundle of the main-memory port.
// The interconnect drives the master side and the RAM is the slave.
interface mem_responder_if;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_rstrb;
  logic [31:0] mem_rdata;
  logic        mem_rbusy;
  logic        mem_wbusy;
  logic        mem_err;

  modport master (
    output mem_addr,
    output mem_wdata,
    output mem_wmask,
    output mem_rstrb,
    input  mem_rdata,
    input  mem_rbusy,
    input  mem_wbusy,
    input  mem_err
  );

  modport slave (
    input  mem_addr,
    input  mem_wdata,
    input  mem_wmask,
    input  mem_rstrb,
    output mem_rdata,
    output mem_rbusy,
    output mem_wbusy,
    output mem_err
  );
endinterface

// File: rtl/mem_responder.sv
// mem_responder: word RAM target with strobed reads and masked writes.
// Define MEM_RESP_ERR_EN for the sticky out-of-range flag.
module mem_responder #(
  parameter int unsigned DEPTH_LOG2 = 12,
  parameter int unsigned READ_LAT   = 2,
  parameter int unsigned WRITE_LAT  = 1,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic           clk,
  input  logic           reset,
  mem_responder_if.slave bus
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [3:0] RD_LOAD = 4'(READ_LAT - 1);
  localparam logic [3:0] WR_LOAD = 4'(WRITE_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [3:0]  r_lat_cnt;
  logic [3:0]  w_lat_cnt_nxt;
  logic [31:0] r_mem [DEPTH];

  logic [DEPTH_LOG2-1:0] r_idx;
  logic [31:0]           r_wdata;
  logic [3:0]            r_wmask;
  logic                  r_oor;
  logic                  r_rbusy;
  logic                  r_wbusy;
  logic [31:0]           r_rdata;

  logic                  w_wr_req;
  logic                  w_rd_req;
  logic                  w_accept;
  logic                  w_oor;
  logic                  w_last;
  logic                  w_rd_done;
  logic                  w_wr_commit;
  logic [DEPTH_LOG2-1:0] w_idx;

  // A write wins over a simultaneous read strobe.
  assign w_wr_req = |bus.mem_wmask;
  assign w_rd_req = bus.mem_rstrb & ~w_wr_req;
  assign w_accept = (r_state == S_IDLE)
                  & (w_wr_req | w_rd_req);

  assign w_idx =
    DEPTH_LOG2'((bus.mem_addr - BASE_ADDR) >> 2);

  assign w_last      = (r_lat_cnt == 4'd0);
  assign w_rd_done   = (r_state == S_RD) & w_last;
  assign w_wr_commit = (r_state == S_WR) & w_last
                     & ~r_oor;

`ifdef MEM_RESP_ERR_EN
  localparam logic [32:0] LIMIT =
    {1'b0, BASE_ADDR} + (33'd4 << DEPTH_LOG2);

  logic r_err;

  assign w_oor = (bus.mem_addr < BASE_ADDR)
               | ({1'b0, bus.mem_addr} >= LIMIT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err <= 1'b0;
    end else if (w_accept & w_oor) begin
      r_err <= 1'b1;
    end
  end

  assign bus.mem_err = r_err;
`else
  assign w_oor       = 1'b0;
  assign bus.mem_err = 1'b0;
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_lat_cnt_nxt = r_lat_cnt;
    unique case (r_state)
      S_IDLE: begin
        unique case (1'b1)
          w_wr_req: begin
            w_state_nxt   = S_WR;
            w_lat_cnt_nxt = WR_LOAD;
          end
          w_rd_req: begin
            w_state_nxt   = S_RD;
            w_lat_cnt_nxt = RD_LOAD;
          end
          default: ;
        endcase
      end
      S_RD, S_WR: begin
        if (w_last) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_lat_cnt_nxt = r_lat_cnt - 4'd1;
        end
      end
      default: begin
        w_state_nxt   = S_IDLE;
        w_lat_cnt_nxt = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_lat_cnt <= 4'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_lat_cnt <= w_lat_cnt_nxt;
    end
  end

  // Busy flags are registered copies of the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rbusy <= 1'b0;
      r_wbusy <= 1'b0;
      r_rdata <= 32'h0;
      r_idx   <= '0;
      r_wdata <= 32'h0;
      r_wmask <= 4'h0;
      r_oor   <= 1'b0;
    end else begin
      r_rbusy <= (w_state_nxt == S_RD);
      r_wbusy <= (w_state_nxt == S_WR);
      if (w_accept) begin
        r_idx   <= w_idx;
        r_wdata <= bus.mem_wdata;
        r_wmask <= bus.mem_wmask;
        r_oor   <= w_oor;
      end
      if (w_rd_done) begin
        r_rdata <= r_oor ? 32'h0 : r_mem[r_idx];
      end
    end
  end

  // RAM keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (w_wr_commit) begin
      for (int i = 0; i < 4; i++) begin
        if (r_wmask[i]) begin
          r_mem[r_idx][8*i +: 8] <= r_wdata[8*i +: 8];
        end
      end
    end
  end

  assign bus.mem_rdata = r_rdata;
  assign bus.mem_rbusy = r_rbusy;
  assign bus.mem_wbusy = r_wbusy;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: random traffic against a transaction-level model,
// plus directed literal checks on a default and a slow instance.
module tb_mem_responder;

  localparam int          DL     = 12;
  localparam int          RL     = 2;
  localparam int          WL     = 1;
  localparam int          DEPTH0 = 1 << DL;
  localparam logic [31:0] BASE   = 32'h0000_0000;

  logic clk  = 1'b0;
  logic rst0 = 1'b1;
  logic rst1 = 1'b1;

  always #5 clk = ~clk;

  mem_responder_if bus0 ();
  mem_responder_if bus1 ();

  mem_responder #(
    .DEPTH_LOG2(DL),
    .READ_LAT  (RL),
    .WRITE_LAT (WL),
    .BASE_ADDR (BASE)
  ) u_dut0 (
    .clk  (clk),
    .reset(rst0),
    .bus  (bus0)
  );

  mem_responder #(
    .DEPTH_LOG2(6),
    .READ_LAT  (3),
    .WRITE_LAT (4),
    .BASE_ADDR (32'h0000_0000)
  ) u_dut1 (
    .clk  (clk),
    .reset(rst1),
    .bus  (bus1)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  // Transaction-level model of instance 0: remaining busy cycles
  // and a word array updated when an access finishes.
  bit [31:0]   m_mem [DEPTH0];
  int          m_left  = 0;
  bit          m_rd    = 1'b0;
  int unsigned m_idx   = 0;
  bit [31:0]   m_wd    = 32'h0;
  bit [3:0]    m_wm    = 4'h0;
  bit          m_oor   = 1'b0;
  bit [31:0]   m_rdata = 32'h0;
  bit          m_err   = 1'b0;

  function automatic bit is_oor(input logic [31:0] a);
`ifdef MEM_RESP_ERR_EN
    longint unsigned lo;
    longint unsigned hi;
    lo = longint'(BASE);
    hi = lo + 4 * longint'(DEPTH0);
    return (longint'(a) < lo) || (longint'(a) >= hi);
`else
    return (a === 32'hx);
`endif
  endfunction

  function automatic bit [31:0] merge(input bit [31:0] old,
                                      input bit [31:0] wd,
                                      input bit [3:0]  wm);
    bit [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) begin
      if (wm[i]) r[8*i +: 8] = wd[8*i +: 8];
    end
    return r;
  endfunction

  always @(posedge clk or negedge rst0) begin
    if (!rst0) begin
      m_left  <= 0;
      m_rdata <= 32'h0;
      m_err   <= 1'b0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        if (m_rd) begin
          m_rdata <= m_oor ? 32'h0 : m_mem[m_idx];
        end else if (!m_oor) begin
          m_mem[m_idx] <= merge(m_mem[m_idx], m_wd, m_wm);
        end
      end
    end else if (bus0.mem_wmask != 4'h0 || bus0.mem_rstrb) begin
      m_rd   <= (bus0.mem_wmask == 4'h0);
      m_left <= (bus0.mem_wmask == 4'h0) ? RL : WL;
      m_idx  <= 32'(((bus0.mem_addr - BASE) >> 2)
                    & 32'(DEPTH0 - 1));
      m_wd   <= bus0.mem_wdata;
      m_wm   <= bus0.mem_wmask;
      m_oor  <= is_oor(bus0.mem_addr);
      if (is_oor(bus0.mem_addr)) m_err <= 1'b1;
    end
  end

  always @(negedge clk) begin
    check("rbusy", bus0.mem_rbusy, (m_left > 0) && m_rd);
    check("wbusy", bus0.mem_wbusy, (m_left > 0) && !m_rd);
    check("rdata", bus0.mem_rdata, m_rdata);
    check("err", bus0.mem_err, m_err);
  end

  task automatic drive(input int sel,
                       input logic [31:0] a,
                       input logic [31:0] d,
                       input logic [3:0]  m,
                       input logic        rs);
    if (sel == 0) begin
      bus0.mem_addr  = a;
      bus0.mem_wdata = d;
      bus0.mem_wmask = m;
      bus0.mem_rstrb = rs;
    end else begin
      bus1.mem_addr  = a;
      bus1.mem_wdata = d;
      bus1.mem_wmask = m;
      bus1.mem_rstrb = rs;
    end
  endtask

  // Starts at a negedge with the target idle and returns at the
  // first negedge where both busy flags read low again.
  task automatic req(input int sel,
                     input logic [31:0] a,
                     input logic [31:0] d,
                     input logic [3:0]  m,
                     input logic        rs,
                     output int         rb,
                     output int         wb);
    bit   done;
    logic r;
    logic w;
    drive(sel, a, d, m, rs);
    @(negedge clk);
    drive(sel, $urandom(), $urandom(), 4'h0, 1'b0);
    rb   = 0;
    wb   = 0;
    done = 1'b0;
    for (int i = 0; i < 64 && !done; i++) begin
      r = (sel == 0) ? bus0.mem_rbusy : bus1.mem_rbusy;
      w = (sel == 0) ? bus0.mem_wbusy : bus1.mem_wbusy;
      if (!r && !w) begin
        done = 1'b1;
      end else begin
        rb += int'(r);
        wb += int'(w);
        @(negedge clk);
      end
    end
    check("req_done", done, 1'b1);
  endtask

  int unsigned pool [16];
  int          rb;
  int          wb;

  initial begin
    drive(0, 32'h0, 32'h0, 4'h0, 1'b0);
    drive(1, 32'h0, 32'h0, 4'h0, 1'b0);
    #1;
    rst0 = 1'b0;
    rst1 = 1'b0;
    repeat (2) @(negedge clk);
    rst0 = 1'b1;
    rst1 = 1'b1;
    check("rst_rbusy", bus0.mem_rbusy, 1'b0);
    check("rst_wbusy", bus0.mem_wbusy, 1'b0);
    check("rst_rdata", bus0.mem_rdata, 32'h0);
    check("rst1_wbusy", bus1.mem_wbusy, 1'b0);

    req(0, 32'h0, 32'h1234_5678, 4'hF, 1'b0, rb, wb);
    req(0, 32'h40, 32'hDEAD_BEEF, 4'hF, 1'b0, rb, wb);
    check("wr_wbusy_cycles", wb, 1);
    check("wr_rbusy_cycles", rb, 0);
    req(0, 32'h40, 32'h0, 4'h0, 1'b1, rb, wb);
    check("rd_rbusy_cycles", rb, 2);
    check("rd_wbusy_cycles", wb, 0);
    check("rd_data", bus0.mem_rdata, 32'hDEAD_BEEF);

    req(0, 32'h80, 32'h1122_3344, 4'hF, 1'b0, rb, wb);
    req(0, 32'h80, 32'hAABB_CCDD, 4'b0101, 1'b0, rb, wb);
    req(0, 32'h83, 32'h0, 4'h0, 1'b1, rb, wb);
    check("mask_data", bus0.mem_rdata, 32'h11BB_33DD);

    req(0, 32'h0, 32'h0000_00FF, 4'h1, 1'b1, rb, wb);
    check("simul_wbusy", wb, 1);
    check("simul_rbusy", rb, 0);
    check("simul_rdata", bus0.mem_rdata, 32'h11BB_33DD);
    req(0, 32'h0, 32'h0, 4'h0, 1'b1, rb, wb);
    check("simul_word0", bus0.mem_rdata, 32'h1234_56FF);

    req(0, 32'h4000, 32'h0, 4'h0, 1'b1, rb, wb);
    check("range_rbusy", rb, RL);
`ifdef MEM_RESP_ERR_EN
    check("range_rdata", bus0.mem_rdata, 32'h0);
    check("range_err", bus0.mem_err, 1'b1);
`else
    check("wrap_rdata", bus0.mem_rdata, 32'h1234_56FF);
    check("wrap_err", bus0.mem_err, 1'b0);
`endif

    for (int k = 0; k < 16; k++) begin
      pool[k] = k * 257;
      req(0, BASE + 32'(pool[k] * 4), $urandom() | 32'h1,
          4'hF, 1'b0, rb, wb);
    end

    for (int n = 0; n < 300; n++) begin
      logic [31:0] a;
      int          op;
      a  = BASE + 32'(pool[$urandom_range(0, 15)] * 4)
         + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a = a + 32'h4000;
      op = $urandom_range(0, 9);
      if (op <= 3) begin
        req(0, a, $urandom(), 4'($urandom_range(1, 15)),
            1'b0, rb, wb);
      end else if (op <= 7) begin
        req(0, a, $urandom(), 4'h0, 1'b1, rb, wb);
      end else if (op == 8) begin
        req(0, a, $urandom(), 4'($urandom_range(1, 15)),
            1'b1, rb, wb);
      end else begin
        drive(0, $urandom(), $urandom(), 4'h0, 1'b0);
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
    end

    drive(0, BASE + 32'(pool[3] * 4), 32'h0, 4'h0, 1'b1);
    @(posedge clk);
    #2;
    rst0 = 1'b0;
    #1;
    check("async_rbusy", bus0.mem_rbusy, 1'b0);
    check("async_wbusy", bus0.mem_wbusy, 1'b0);
    check("async_rdata", bus0.mem_rdata, 32'h0);
    check("async_err", bus0.mem_err, 1'b0);
    drive(0, 32'h0, 32'h0, 4'h0, 1'b0);
    repeat (10) begin
      @(negedge clk);
      check("hold_rbusy", bus0.mem_rbusy, 1'b0);
      check("hold_rdata", bus0.mem_rdata, 32'h0);
    end
    rst0 = 1'b1;
    req(0, BASE + 32'(pool[5] * 4), 32'h0, 4'h0, 1'b1, rb, wb);

    req(1, 32'h10, 32'hCAFE_F00D, 4'hF, 1'b0, rb, wb);
    check("d1_wbusy_cycles", wb, 4);
    req(1, 32'h10, 32'h0, 4'h0, 1'b1, rb, wb);
    check("d1_rbusy_cycles", rb, 3);
    check("d1_rdata", bus1.mem_rdata, 32'hCAFE_F00D);
    drive(1, 32'h10, 32'h5555_5555, 4'hF, 1'b0);
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("d1_wbusy_pre", bus1.mem_wbusy, 1'b1);
    #1;
    rst1 = 1'b0;
    #1;
    check("d1_abort_wbusy", bus1.mem_wbusy, 1'b0);
    check("d1_abort_rdata", bus1.mem_rdata, 32'h0);
    @(negedge clk);
    drive(1, 32'h0, 32'h0, 4'h0, 1'b0);
    @(negedge clk);
    rst1 = 1'b1;
    req(1, 32'h10, 32'h0, 4'h0, 1'b1, rb, wb);
    check("d1_old_value", bus1.mem_rdata, 32'hCAFE_F00D);
    check("d1_rbusy_again", rb, 3);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog expired");
  end

endmodule
